// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared constants, state encoding and opcode helper for the
//               instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    // Upper nibble that marks the first byte of a two-byte instruction.
    localparam logic [3:0] TWO_BYTE_OPC     = 4'hC;

    // PC value loaded by reset unless the instance overrides it.
    localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } ifu_state_e;

    // True when the byte opens a two-byte instruction.
    function automatic logic is_two_byte(input logic [7:0] opc);
        return (opc[7:4] == TWO_BYTE_OPC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small prefetch FIFO holding {byte, addr} entries. Synchronous
//               clear has priority over push; push and pop together are both
//               honored even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping; clear wins over any push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Entry storage; contents are qualified by the occupancy count, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !clr) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Processor front end. Owns the PC, fetches bytes over a
//               req/ack memory handshake under a credit limit, buffers them
//               in a prefetch FIFO and delivers one byte per cycle to the IR
//               stage, tagging the second byte of two-byte instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter int            DEPTH    = 2,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_data,
    output logic [DW-1:0] ir_new,
    output logic          ld,
    output logic          sf1,
    output logic [AW-1:0] pc_out
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    ifu_state_e         r_state;
    ifu_state_e         w_state_next;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      r_hold_addr;
    logic               r_second_pending;

    logic [DW+AW-1:0]   w_fifo_rdata;
    logic [DW-1:0]      w_head_byte;
    logic [AW-1:0]      w_head_addr;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_credit_next;

    assign w_head_byte = w_fifo_rdata[DW+AW-1:AW];
    assign w_head_addr = w_fifo_rdata[AW-1:0];

    // Redirect outranks stall; a redirected cycle never delivers.
    assign w_pop  = ~w_empty & ~stall & ~redirect;

    // Only a live REQ read is kept; DISCARD/IDLE acks and redirected acks drop.
    assign w_push = (r_state == REQ) & imem_ack & ~redirect & (~w_full | w_pop);

    // Occupancy after this cycle's push/pop decides whether another read fits.
    // A redirect empties the FIFO, so credit is always available afterwards.
    assign w_count_next  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_credit_next = redirect | (w_count_next < c_depth);

    fetch_fifo #(
        .WIDTH (DW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({imem_data, r_pc}),
        .rdata (w_fifo_rdata),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // Fetch sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Next-state and memory-port outputs; an unacked read cannot be aborted,
    // so a redirect during it drains through DISCARD at the old address.
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        imem_addr    = r_pc;
        case (r_state)
            IDLE: begin
                if (w_credit_next) w_state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack)      w_state_next = w_credit_next ? REQ : IDLE;
                else if (redirect) w_state_next = DISCARD;
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = r_hold_addr;
                if (imem_ack) w_state_next = REQ;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Program counter: redirect target, else advance on each kept byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_pc <= RESET_PC;
        else if (redirect) r_pc <= redirect_pc;
        else if (w_push)   r_pc <= r_pc + AW'(1);
    end

    // Address of the abandoned read, held on the bus until its ack arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_hold_addr <= RESET_PC;
        else if ((r_state == REQ) && redirect && !imem_ack)
            r_hold_addr <= r_pc;
    end

    // Second-byte tracker: armed by a delivered two-byte opcode, consumed by
    // the following delivery, and forgotten on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_second_pending <= 1'b0;
        else if (redirect) r_second_pending <= 1'b0;
        else if (w_pop)    r_second_pending <= ~r_second_pending & is_two_byte(w_head_byte[7:0]);
    end

    assign ld     = w_pop;
    assign sf1    = w_pop & r_second_pending;
    assign ir_new = w_pop ? w_head_byte : '0;
    assign pc_out = w_pop ? w_head_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               wait-state-configurable ROM model and a second instance
//               reset to 8'hFE for PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, redirect, ack_extra;
    logic [7:0] redirect_pc;
    logic       imem_req, imem_ack, ld, sf1;
    logic [7:0] imem_addr, imem_data, ir_new, pc_out;

    logic       pw_stall, pw_redirect;
    logic [7:0] pw_redirect_pc;
    logic       pw_req, pw_ack, pw_ld, pw_sf1;
    logic [7:0] pw_addr, pw_data, pw_ir, pw_pc;

    logic [7:0] rom [256];
    int         ws;
    int         wcnt;
    int         reads;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.AW(8), .DW(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ir_new(ir_new),
        .ld(ld), .sf1(sf1), .pc_out(pc_out)
    );

    instr_fetch_unit #(.AW(8), .DW(8), .DEPTH(2), .RESET_PC(8'hFE)) dut_w (
        .clk(clk), .rst(rst), .stall(pw_stall), .redirect(pw_redirect),
        .redirect_pc(pw_redirect_pc), .imem_req(pw_req), .imem_addr(pw_addr),
        .imem_ack(pw_ack), .imem_data(pw_data), .ir_new(pw_ir),
        .ld(pw_ld), .sf1(pw_sf1), .pc_out(pw_pc)
    );

    // ROM with ws wait states; ack_extra injects a stray ack.
    assign imem_ack  = (imem_req && (wcnt >= ws)) || ack_extra;
    assign imem_data = rom[imem_addr];
    assign pw_ack    = pw_req;
    assign pw_data   = rom[pw_addr];

    // Wait-state counter and count of completed reads.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt  <= 0;
            reads <= 0;
        end else begin
            if (imem_req && !imem_ack) wcnt <= wcnt + 1;
            else                       wcnt <= 0;
            if (imem_req && imem_ack)  reads <= reads + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dx(input logic l, input logic s,
                                       input logic [7:0] p, input logic [7:0] b);
        return {14'b0, l, s, p, b};
    endfunction

    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    // Reset, then release at a falling edge: the current cycle is cycle 0.
    task automatic start_run(input logic st, input int wait_states);
        rst = 1'b0; stall = st; redirect = 1'b0; ack_extra = 1'b0; ws = wait_states;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        ack_extra = 1'b0; ws = 0;
        pw_stall = 1'b0; pw_redirect = 1'b0; pw_redirect_pc = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[8'h00] = 8'h10; rom[8'h01] = 8'hC3; rom[8'h02] = 8'h55; rom[8'h03] = 8'h20;
        rom[8'h40] = 8'h31; rom[8'h41] = 8'h42;

        // Reset values
        nc();
        chk("rst_req",  32'(imem_req), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_out",  dx(ld, sf1, pc_out, ir_new), 32'h0);
        chk("rst_waddr", 32'(pw_addr), 32'hFE);

        // Zero-wait streaming, plus PC wrap on the FE instance
        start_run(1'b0, 0);
        chk("t1_c0_req", 32'(imem_req), 32'h0);
        nc();
        chk("t1_c1_req",  32'({imem_req, imem_addr}), 32'h100);
        chk("wrap_a0",    32'(pw_addr), 32'hFE);
        nc();
        chk("t1_d0", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h00, 8'h10));
        chk("wrap_a1",    32'(pw_addr), 32'hFF);
        chk("wrap_d0", dx(pw_ld, pw_sf1, pw_pc, pw_ir), dx(1'b1, 1'b0, 8'hFE, 8'hA4));
        nc();
        chk("t1_d1", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h01, 8'hC3));
        chk("wrap_a2",    32'(pw_addr), 32'h00);
        chk("wrap_d1", dx(pw_ld, pw_sf1, pw_pc, pw_ir), dx(1'b1, 1'b0, 8'hFF, 8'hA5));
        nc();
        chk("t1_d2", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b1, 8'h02, 8'h55));
        chk("wrap_a3",    32'(pw_addr), 32'h01);
        nc();
        chk("t1_d3", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h03, 8'h20));

        // Stall for 6 cycles: credit limits fetch to DEPTH reads
        start_run(1'b1, 0);
        nc();
        chk("t2_c1", 32'({imem_req, imem_addr}), 32'h100);
        nc();
        chk("t2_c2", 32'({imem_req, imem_addr}), 32'h101);
        nc();
        chk("t2_c3_req", 32'(imem_req), 32'h0);
        @(negedge clk); ack_extra = 1'b1; #1;
        chk("t2_c4_ld", 32'(ld), 32'h0);
        @(negedge clk); ack_extra = 1'b0; #1;
        chk("t2_reads", 32'(reads), 32'd2);
        chk("t2_c5_req", 32'(imem_req), 32'h0);
        @(negedge clk); stall = 1'b0; #1;
        chk("t2_d0", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h00, 8'h10));
        nc();
        chk("t2_d1", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h01, 8'hC3));
        chk("t2_resume", 32'({imem_req, imem_addr}), 32'h102);
        nc();
        chk("t2_d2", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b1, 8'h02, 8'h55));

        // 3 wait states, redirect while addr 1 is pending
        start_run(1'b0, 3);
        nc(); nc(); nc(); nc();
        chk("t3_c4_ack", 32'({imem_ack, imem_addr}), 32'h100);
        nc();
        chk("t3_d0", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h00, 8'h10));
        @(negedge clk); redirect = 1'b1; redirect_pc = 8'h40; #1;
        chk("t3_c6", 32'({imem_req, ld, imem_addr}), 32'h201);
        @(negedge clk); redirect = 1'b0; #1;
        chk("t3_c7_hold", 32'({imem_req, imem_addr}), 32'h101);
        nc();
        chk("t3_c8_ack", 32'({imem_ack, imem_addr}), 32'h101);
        nc();
        chk("t3_c9", 32'({imem_req, ld, imem_addr}), 32'h240);
        nc(); nc(); nc();
        chk("t3_c12", 32'({imem_ack, ld, imem_addr}), 32'h240);
        nc();
        chk("t3_d40", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h40, 8'h31));

        // Redirect with a second byte pending
        start_run(1'b0, 0);
        nc(); nc(); nc();
        chk("t4_dC3", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h01, 8'hC3));
        @(negedge clk); redirect = 1'b1; redirect_pc = 8'h40; #1;
        chk("t4_c4_ld", 32'(ld), 32'h0);
        @(negedge clk); redirect = 1'b0; #1;
        chk("t4_c5", 32'({imem_req, ld, imem_addr}), 32'h240);
        nc();
        chk("t4_d40", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h40, 8'h31));
        nc();
        chk("t4_d41", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h41, 8'h42));

        // Asynchronous reset mid-fetch with the FIFO filling
        start_run(1'b1, 0);
        nc(); nc();
        chk("t6_pre", 32'({imem_req, imem_addr}), 32'h101);
        #1; rst = 1'b0; stall = 1'b0; #1;
        chk("t6_req",  32'({imem_req, imem_addr}), 32'h000);
        chk("t6_out",  dx(ld, sf1, pc_out, ir_new), 32'h0);
        @(negedge clk); @(negedge clk); rst = 1'b1; #1;
        chk("t6_c0_req", 32'(imem_req), 32'h0);
        nc();
        chk("t6_c1", 32'({imem_req, imem_addr}), 32'h100);
        nc();
        chk("t6_d0", dx(ld, sf1, pc_out, ir_new), dx(1'b1, 1'b0, 8'h00, 8'h10));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
